// File: rtl/serial_add_sub_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_sub_ctrl_pkg
// Shared definitions for the bit-serial adder/subtractor and its bench:
//   state_e  - controller state encoding (IDLE, RUN, DONE)
//   OP_ADD / OP_SUB - operation select encodings
//   mux2()   - the 2:1 mux primitive the 1-bit datapath slice is built from
// -----------------------------------------------------------------------------
package serial_add_sub_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // 2:1 mux primitive: returns d1 when sel is high, d0 otherwise.
  function automatic logic mux2(input logic sel, input logic d0, input logic d1);
    return sel ? d1 : d0;
  endfunction

endpackage : serial_add_sub_ctrl_pkg

// File: rtl/serial_add_sub_ctrl_fa_fs_slice.sv
// -----------------------------------------------------------------------------
// fa_fs_slice
// One-bit combinational full-adder / full-subtractor, built only from mux2.
//   x, y  - operand bits
//   cin   - carry-in (add) or borrow-in (subtract)
//   op    - OP_ADD computes x+y+cin, OP_SUB computes x-y-cin
//   r     - sum or difference bit
//   cout  - carry-out (add) or borrow-out (subtract)
// -----------------------------------------------------------------------------
module fa_fs_slice
  import serial_add_sub_ctrl_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  input  logic op,
  output logic r,
  output logic cout
);

  logic w_p;
  logic w_add_cout;
  logic w_sub_bout;

  // Sum and difference bits are identical: x ^ y ^ cin.
  assign w_p = x ^ y;
  assign r   = mux2(cin, w_p, ~w_p);

  // Add: when x != y the incoming carry propagates, otherwise x (== y)
  // generates or kills it.
  assign w_add_cout = mux2(w_p, x, cin);

  // Subtract: when x == y the incoming borrow propagates, otherwise a borrow
  // is generated exactly when y is the 1 (x=0, y=1).
  assign w_sub_bout = mux2(w_p, cin, y);

  assign cout = mux2(op, w_add_cout, w_sub_bout);

endmodule : fa_fs_slice

// File: rtl/serial_add_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_sub_ctrl
// Bit-serial add/subtract unit: one result bit per clock, LSB first, through a
// single fa_fs_slice. An operation takes WIDTH cycles in RUN plus one DONE
// cycle; a new start is only accepted in IDLE.
//   clk    - clock, all state updates on the rising edge
//   rst    - synchronous active-high reset
//   start  - request an operation (sampled in IDLE only)
//   op     - OP_ADD (a+b) or OP_SUB (a-b), sampled with start
//   a, b   - WIDTH-bit operands, sampled with start
//   busy   - high exactly while in RUN
//   done   - one-cycle pulse when result/cy/ovf become valid
//   result - sum or difference, held until the next accepted start
//   cy     - carry-out (add) / borrow-out (subtract) of the MSB
//   ovf    - two's-complement signed overflow
// -----------------------------------------------------------------------------
module serial_add_sub_ctrl
  import serial_add_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cy,
  output logic             ovf
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_op;
  logic             r_cb;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cy;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_r;
  logic             w_cout;

  fa_fs_slice u_slice (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .cin  (r_cb),
    .op   (r_op),
    .r    (w_r),
    .cout (w_cout)
  );

  // NOTE: every register here is state updated on the clock edge, so all
  // assignments are non-blocking; blocking ones would let later statements
  // see this cycle's new values and break the shift/flag timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the operand shift registers are reset along with the control
      // state so nothing left over from an aborted operation is observable.
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_cb     <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cy     <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_cb    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end

        RUN: begin
          // Slice output enters at the MSB; after WIDTH shifts bit 0 lands
          // at result[0].
          r_result <= {w_r, r_result[WIDTH-1:1]};
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_cb     <= w_cout;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CNT_LAST) begin
            // This cycle processes the MSB: r_cb is the carry/borrow into
            // it and w_cout the one out of it.
            r_cy    <= w_cout;
            r_ovf   <= r_cb ^ w_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cy     = r_cy;
  assign ovf    = r_ovf;

endmodule : serial_add_sub_ctrl
